radix4_booth_mul: RTL and testbench

Sequential radix-4 Booth multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions. It is the multiply counterpart of the radix-4 SRT divider and shares the execute-stage M-extension slot with it. The multiplier retires two bits per cycle with a start/busy/done handshake and returns one 32-bit result selected by op.

---
 rtl/radix4_booth_mul.sv | 172 +++++++++++++++++
 tb/tb_radix4_booth_mul.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/radix4_booth_mul.sv
// ---------------------------------------------------------------------------
// radix4_booth_mul
//
// Sequential radix-4 Booth multiplier for the RV32M MUL/MULH/MULHSU/MULHU
// instructions. It retires two multiplier bits per cycle and returns one
// N-bit result selected by op. It uses a start/busy/done handshake.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   start         request pulse, sampled only while idle
//   multiplicand  rs1 operand, captured when start is accepted
//   multiplier    rs2 operand, captured when start is accepted
//   op            00 MUL (low half), 01 MULH (s x s), 10 MULHSU (s x u),
//                 11 MULHU (u x u); the last three return the high half
//   out           result, held until the next completion
//   busy          high whenever the engine is not idle
//   done          one-cycle pulse, out is valid in the same cycle
//
// Timing: start accepted at E0, iterations at E1..E(N/2+1), result edge at
// E(N/2+2). If either operand is zero, the engine skips the iterations and
// the result edge is E1.
// ---------------------------------------------------------------------------
module radix4_booth_mul #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] multiplicand,
    input  logic [N-1:0] multiplier,
    input  logic [1:0]   op,
    output logic [N-1:0] out,
    output logic         busy,
    output logic         done
);

    // Operands are extended to N+2 bits so that every signedness mode can be
    // handled by one signed Booth recoding. The running partial sum has two
    // guard bits above the extended width. These bits absorb the +/-2A digit
    // before the arithmetic shift, so that the shift sees the true sign.
    localparam int XW    = N + 2;
    localparam int HW    = N + 4;
    localparam int ITER  = N / 2 + 1;
    localparam int CW    = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [1:0]      op_reg;
    logic [XW-1:0]   a_reg;      // extended multiplicand
    logic [HW-1:0]   hi_reg;     // upper (accumulating) half of the pair
    logic [XW-1:0]   lo_reg;     // multiplier, replaced by product bits as it shifts
    logic            z_reg;      // bit just below lo_reg[0] (implicit 0 at start)
    logic [CW-1:0]   count_reg;
    logic [N-1:0]    out_reg;
    logic            done_reg;

    // ---------------- operand extension at capture ----------------
    logic          a_signed;
    logic          b_signed;
    logic [XW-1:0] a_ext;
    logic [XW-1:0] b_ext;
    logic          zero_operand;

    assign a_signed     = (op != 2'b11);
    assign b_signed     = ~op[1];
    assign a_ext        = {{2{a_signed & multiplicand[N-1]}}, multiplicand};
    assign b_ext        = {{2{b_signed & multiplier[N-1]}}, multiplier};
    assign zero_operand = (multiplicand == '0) || (multiplier == '0);

    // ---------------- Booth digit selection ----------------
    logic [2:0]    win;
    logic [HW-1:0] a_wide;
    logic [HW-1:0] a_dbl;
    logic [HW-1:0] pp;
    logic [HW-1:0] sum;
    logic [HW-1:0] hi_next;
    logic [XW-1:0] lo_next;

    assign win    = {lo_reg[1:0], z_reg};
    assign a_wide = {{2{a_reg[XW-1]}}, a_reg};
    assign a_dbl  = {a_wide[HW-2:0], 1'b0};

    always_comb begin
        pp = '0;
        case (win)
            3'b001, 3'b010: pp = a_wide;
            3'b011:         pp = a_dbl;
            3'b100:         pp = '0 - a_dbl;
            3'b101, 3'b110: pp = '0 - a_wide;
            default:        pp = '0;
        endcase
    end

    assign sum = hi_reg + pp;

    // Arithmetic shift right by 2 of the pair {sum, lo_reg, z_reg}
    assign hi_next = {{2{sum[HW-1]}}, sum[HW-1:2]};
    assign lo_next = {sum[1:0], lo_reg[XW-1:2]};

    // After all iterations the pair holds the product with bit 0 at
    // lo_reg[0]. The high result half therefore straddles both registers.
    logic [N-1:0] prod_low;
    logic [N-1:0] prod_high;

    assign prod_low  = lo_reg[N-1:0];
    assign prod_high = {hi_reg[N-3:0], lo_reg[N+1:N]};

    // ---------------- control and datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            a_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            z_reg     <= 1'b0;
            count_reg <= '0;
            out_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg    <= op;
                        a_reg     <= a_ext;
                        hi_reg    <= '0;
                        z_reg     <= 1'b0;
                        count_reg <= '0;
                        if (zero_operand) begin
                            // Clearing the multiplier leaves the whole pair at
                            // zero, which is the product.
                            lo_reg    <= '0;
                            state_reg <= DONE;
                        end else begin
                            lo_reg    <= b_ext;
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    hi_reg    <= hi_next;
                    lo_reg    <= lo_next;
                    z_reg     <= lo_reg[1];
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == CW'(ITER - 1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    out_reg   <= (op_reg == 2'b00) ? prod_low : prod_high;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out  = out_reg;
    assign done = done_reg;
    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_radix4_booth_mul.sv
// ---------------------------------------------------------------------------
// tb_radix4_booth_mul
//
// This bench checks radix4_booth_mul (N=32) with a scoreboard. The driver
// pushes each expected result, issue edge and latency into a queue. A monitor
// pops one entry on every done pulse and compares out and latency. On every
// other cycle, the monitor checks that out holds its value. Expected values
// come from a 66-bit integer product of the sign- or zero-extended operands.
// ---------------------------------------------------------------------------
module tb_radix4_booth_mul;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [1:0]  op;
    logic [31:0] out;
    logic        busy;
    logic        done;

    radix4_booth_mul #(.N(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .op           (op),
        .out          (out),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    typedef struct {
        logic [31:0] exp;
        int          e0;
        int          lat;
    } sb_t;

    sb_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide integer multiply of the extended operands
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] o);
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        logic signed [65:0] p;
        sa = (o != 2'b11) ? {{34{a[31]}}, a} : {34'b0, a};
        sb = (o[1] == 1'b0) ? {{34{b[31]}}, b} : {34'b0, b};
        p  = sa * sb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // ---------------- monitor ----------------
    logic [31:0] last_out = '0;

    always @(negedge clk) begin : mon
        sb_t e;
        if (!rst) begin
            last_out = '0;
        end else if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                e = sb_q.pop_front();
                $display("txn: out=%08h exp=%08h latency=%0d", out, e.exp, cycle_cnt - e.e0);
                check("result", 64'(out), 64'(e.exp));
                check("latency", 64'(cycle_cnt - e.e0), 64'(e.lat));
            end
            last_out = out;
        end else begin
            check("out_hold", 64'(out), 64'(last_out));
        end
    end

    // ---------------- driver ----------------
    // Call just after a falling edge. The task returns at the falling edge
    // where done is seen, so the next call issues in the done cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                          input logic [31:0] exp, input int inject);
        int lat;
        int busy_n;
        bit seen;
        lat    = (a == 0 || b == 0) ? 1 : 18;
        busy_n = 0;
        seen   = 1'b0;
        multiplicand = a;
        multiplier   = b;
        op           = o;
        start        = 1'b1;
        sb_q.push_back('{exp, cycle_cnt + 1, lat});
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            // These inputs change while the engine is busy. The DUT must ignore them.
            start        = (k == inject);
            multiplicand = $urandom;
            multiplier   = $urandom;
            op           = 2'($urandom_range(0, 3));
        end
        start = 1'b0;
        check("done_seen", 64'(seen), 64'd1);
        check("busy_cycles", 64'(busy_n), 64'(lat));
    endtask

    initial begin : wdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : drv
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        int          inj;
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        op           = '0;
        #3 rst = 1'b0;
        #1;
        check("reset_out", 64'(out), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors
        run_op(32'd7,        32'hFFFFFFFD, 2'b00, 32'hFFFFFFEB, -1);
        run_op(32'h80000000, 32'h80000000, 2'b01, 32'h40000000, -1);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'hFFFFFFFE, -1);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFF, -1);
        run_op(32'h00000002, 32'h80000000, 2'b10, 32'h00000001, -1);
        run_op(32'd0,        32'h12345678, 2'b11, 32'h00000000, -1);
        run_op(32'd3,        32'd5,        2'b00, 32'h0000000F, -1);   // issued in done cycle
        run_op(32'd6,        32'd7,        2'b00, 32'h0000002A, 4);    // start mid-run ignored

        // Reset in the middle of a MUL: result discarded, no done pulse
        multiplicand = 32'h1234;
        multiplier   = 32'h5678;
        op           = 2'b00;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_out", 64'(out), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        @(negedge clk);
        check("midreset_done_hold", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(32'd9, 32'd9, 2'b00, 32'h00000051, -1);

        // Randomized transactions against the reference model
        for (int t = 0; t < 80; t++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a = '0;
                1: b = '0;
                2: a = 32'h80000000;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            o   = 2'($urandom_range(0, 3));
            inj = (a == 0 || b == 0 || $urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 16));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_op(a, b, o, ref_mul(a, b, o), inj);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
